// File: rtl/mdio_frame_dri_pkg.sv
// MDIO frame driver shared definitions: frame field codes, bit
// positions within the 64-bit frame, FSM state encoding and a helper
// that maps a frame bit index to the state that transmits it.
package mdio_frame_dri_pkg;

    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] TA_WRITE = 2'b10;
    // Read TA/data are not driven; ones keep the shifter harmless.
    localparam logic [1:0] TA_READ  = 2'b11;

    // Bit positions in the 64-bit frame (preamble is bits 0..31).
    localparam logic [5:0] PRE_LEN    = 6'd32;
    localparam logic [5:0] TA_FIRST   = 6'd46;
    localparam logic [5:0] TA_LAST    = 6'd47;
    localparam logic [5:0] DATA_FIRST = 6'd48;
    localparam logic [5:0] LAST_BIT   = 6'd63;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HDR  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4,
        S_DONE = 3'd5
    } state_t;

    function automatic state_t bit_state(input logic [5:0] b);
        if (b < PRE_LEN)         return S_PRE;
        else if (b < TA_FIRST)   return S_HDR;
        else if (b < DATA_FIRST) return S_TA;
        else                     return S_DATA;
    endfunction

endpackage

// File: rtl/mdio_clk_en.sv
// MDC divider: counts 0..2*CLK_DIV-1 per bit while run is high.
// Ports: clk, rst_n (sync, active-low), run; mdc, rise (first MDC-high
// cycle, used to sample), fall (last cycle of the bit period).
module mdio_clk_en #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic mdc,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;

    always_comb begin
        cnt_nx = (cnt == LAST) ? '0 : cnt + CW'(1);
    end

    assign rise = run && (cnt == HALF);
    assign fall = run && (cnt == LAST);

    // mdc is registered from the next count so it is high exactly
    // while cnt is in the upper half of the bit period.
    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else begin
            cnt <= cnt_nx;
            mdc <= (cnt_nx >= HALF);
        end
    end

endmodule

// File: rtl/mdio_frame_dri.sv
// MDIO (clause 22) frame driver: one 64-bit read or write frame per op_exec.
// Ports: op_* request/response, busy, eth_mdc, mdio_o/mdio_oe/mdio_i pad.
module mdio_frame_dri
    import mdio_frame_dri_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'h07,
    parameter int         CLK_DIV  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_exec,
    input  logic        op_rh_wl,
    input  logic [4:0]  op_addr,
    input  logic [15:0] op_wr_data,
    output logic        op_done,
    output logic        op_rd_ack,
    output logic [15:0] op_rd_data,
    output logic        busy,
    output logic        eth_mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    state_t      state;
    logic        rd;
    logic [63:0] sreg;
    logic [5:0]  bcnt;
    logic [5:0]  bnext;
    logic [63:0] frame;
    logic        run;
    logic        rise;
    logic        fall;

    assign run   = state inside {S_PRE, S_HDR, S_TA, S_DATA};
    assign bnext = bcnt + 6'd1;
    assign frame = {32'hFFFF_FFFF, ST_CODE,
                    op_rh_wl ? OP_READ : OP_WRITE,
                    PHY_ADDR, op_addr,
                    op_rh_wl ? TA_READ : TA_WRITE,
                    op_rh_wl ? 16'hFFFF : op_wr_data};

    mdio_clk_en #(.CLK_DIV(CLK_DIV)) u_clk_en (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (run),
        .mdc  (eth_mdc),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk) begin
        op_done <= 1'b0;
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            op_rd_ack  <= 1'b1;
            op_rd_data <= 16'h0000;
            mdio_oe    <= 1'b0;
            mdio_o     <= 1'b1;
            rd         <= 1'b0;
            sreg       <= '0;
            bcnt       <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (op_exec) begin
                        // Bit 0 goes out now; the rest waits in sreg.
                        rd      <= op_rh_wl;
                        sreg    <= {frame[62:0], 1'b0};
                        mdio_o  <= frame[63];
                        mdio_oe <= 1'b1;
                        busy    <= 1'b1;
                        bcnt    <= '0;
                        state   <= S_PRE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    if (rise && bcnt == TA_LAST)
                        op_rd_ack <= rd & mdio_i;
                    if (rise && rd && bcnt >= DATA_FIRST)
                        op_rd_data <= {op_rd_data[14:0], mdio_i};
                    if (fall) begin
                        if (bcnt == LAST_BIT) begin
                            op_done <= 1'b1;
                            mdio_oe <= 1'b0;
                            mdio_o  <= 1'b1;
                            bcnt    <= '0;
                            state   <= S_DONE;
                        end else begin
                            bcnt    <= bnext;
                            state   <= bit_state(bnext);
                            mdio_o  <= sreg[63];
                            sreg    <= {sreg[62:0], 1'b0};
                            // Reads release the line from TA onward.
                            mdio_oe <= !(rd && bnext >= TA_FIRST);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_frame_dri.sv
// Self-checking bench for mdio_frame_dri with CLK_DIV=2 (4 clk/bit).
// Table of frames plus hand sequences for reset-abort and rejection.
module tb_mdio_frame_dri;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_exec;
    logic        op_rh_wl;
    logic [4:0]  op_addr;
    logic [15:0] op_wr_data;
    logic        op_done;
    logic        op_rd_ack;
    logic [15:0] op_rd_data;
    logic        busy;
    logic        eth_mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i;

    int total  = 0;
    int passed = 0;

    mdio_frame_dri #(.PHY_ADDR(5'h07), .CLK_DIV(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_exec   (op_exec),
        .op_rh_wl  (op_rh_wl),
        .op_addr   (op_addr),
        .op_wr_data(op_wr_data),
        .op_done   (op_done),
        .op_rd_ack (op_rd_ack),
        .op_rd_data(op_rd_data),
        .busy      (busy),
        .eth_mdc   (eth_mdc),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .mdio_i    (mdio_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [4:0]  addr;
        logic [15:0] wd;
        logic        phy;
        logic [15:0] pd;
        logic        poke;
        int          tail;
        logic [63:0] frm;
        logic [63:0] msk;
        logic        ack;
        logic [15:0] rdd;
    } vec_t;

    localparam logic [63:0] RMASK = 64'hFFFF_FFFF_FFFC_0000;
    localparam logic [63:0] WMASK = 64'hFFFF_FFFF_FFFF_FFFF;

    vec_t v[5];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", name, got, exp);
        else
            passed++;
    endtask

    initial begin
        int          done_at;
        int          dones;
        int          b;
        int          ph;
        logic [63:0] seen;
        logic        oe_err;
        logic        mdc_err;
        logic        busy_err;

        v[0] = '{1'b1, 5'd2, 16'h0000, 1'b1, 16'h0141, 1'b0, 4,
                 64'hFFFF_FFFF_638B_FFFF, RMASK, 1'b0, 16'h0141};
        v[1] = '{1'b0, 5'd0, 16'h8140, 1'b0, 16'h0000, 1'b0, 4,
                 64'hFFFF_FFFF_5382_8140, WMASK, 1'b0, 16'h0141};
        v[2] = '{1'b1, 5'd1, 16'h0000, 1'b0, 16'h0000, 1'b0, 0,
                 64'hFFFF_FFFF_6387_FFFF, RMASK, 1'b1, 16'hFFFF};
        v[3] = '{1'b1, 5'd27, 16'h0000, 1'b1, 16'h3C5A, 1'b0, 4,
                 64'hFFFF_FFFF_63EF_FFFF, RMASK, 1'b0, 16'h3C5A};
        v[4] = '{1'b0, 5'd5, 16'hA5C3, 1'b0, 16'h0000, 1'b1, 8,
                 64'hFFFF_FFFF_5396_A5C3, WMASK, 1'b0, 16'h3C5A};

        rst_n = 1'b0; op_exec = 1'b0; op_rh_wl = 1'b0;
        op_addr = '0; op_wr_data = '0; mdio_i = 1'b1;
        repeat (3) tick();

        chk("rst_busy", busy, 1'b0);
        chk("rst_done", op_done, 1'b0);
        chk("rst_ack", op_rd_ack, 1'b1);
        chk("rst_data", op_rd_data, 16'h0000);
        chk("rst_mdc", eth_mdc, 1'b0);
        chk("rst_oe", mdio_oe, 1'b0);
        chk("rst_o", mdio_o, 1'b1);
        rst_n = 1'b1;
        tick();

        // Reset in the first cycle of bit 40 of a read.
        op_exec = 1'b1; op_rh_wl = 1'b1; op_addr = 5'd3;
        tick();
        op_exec = 1'b0;
        dones = 0;
        for (int k = 1; k <= 160; k++) begin
            if (op_done === 1'b1) dones++;
            tick();
        end
        chk("abort_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("abort_mdc", eth_mdc, 1'b0);
        chk("abort_oe", mdio_oe, 1'b0);
        chk("abort_o", mdio_o, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", op_done, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (op_done === 1'b1) dones++;
            tick();
        end
        chk("abort_no_done", 32'(dones), 32'd0);

        for (int i = 0; i < 5; i++) begin
            op_exec = 1'b1; op_rh_wl = v[i].rd;
            op_addr = v[i].addr; op_wr_data = v[i].wd;
            tick();
            op_exec = 1'b0;
            done_at = -1; dones = 0; seen = '0;
            oe_err = 1'b0; mdc_err = 1'b0; busy_err = 1'b0;
            for (int k = 1; k <= 257 + v[i].tail; k++) begin
                if (op_done === 1'b1) begin
                    dones++;
                    if (done_at < 0) done_at = k;
                end
                mdio_i = 1'b1;
                if (k <= 256) begin
                    b  = (k - 1) / 4;
                    ph = (k - 1) % 4;
                    if (ph == 0) seen[63-b] = mdio_o;
                    if (mdio_oe !== (v[i].rd ? (b < 46) : 1'b1))
                        oe_err = 1'b1;
                    if (eth_mdc !== (ph >= 2)) mdc_err = 1'b1;
                    if (busy !== 1'b1) busy_err = 1'b1;
                    if (v[i].rd && v[i].phy) begin
                        if (b == 47) mdio_i = 1'b0;
                        else if (b >= 48) mdio_i = v[i].pd[63-b];
                    end
                end
                op_exec = v[i].poke && (k == 41 || k == 257);
                tick();
            end
            op_exec = 1'b0;
            chk($sformatf("v%0d_done_at", i), 32'(done_at), 32'd257);
            chk($sformatf("v%0d_done_cnt", i), 32'(dones), 32'd1);
            chk($sformatf("v%0d_frame", i),
                seen & v[i].msk, v[i].frm & v[i].msk);
            chk($sformatf("v%0d_oe", i), oe_err, 1'b0);
            chk($sformatf("v%0d_mdc", i), mdc_err, 1'b0);
            chk($sformatf("v%0d_busy", i), busy_err, 1'b0);
            chk($sformatf("v%0d_ack", i), op_rd_ack, v[i].ack);
            chk($sformatf("v%0d_rdata", i), op_rd_data, v[i].rdd);
            chk($sformatf("v%0d_busy_after", i), busy, 1'b0);
            chk($sformatf("v%0d_idle_oe", i), mdio_oe, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
